// File: rtl/bus_arbiter_if.sv
// Pi transaction handshake and SRAM/IO bus pins shared by the arbiter.
// The slave modport is the arbiter side; master is the SPI bridge + SRAM pin side.
interface bus_arbiter_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 8
);
    logic                  pi_req;
    logic                  pi_rw;
    logic [ADDR_WIDTH-1:0] pi_addr;
    logic [DATA_WIDTH-1:0] pi_wdata;
    logic                  pi_ack;
    logic [DATA_WIDTH-1:0] pi_rdata;
    logic                  pi_err;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic                  ram_dout_oe;
    logic                  ram_oe_n;
    logic                  ram_we_n;

    modport master (
        output pi_req, pi_rw, pi_addr, pi_wdata, ram_din,
        input  pi_ack, pi_rdata, pi_err, ram_addr, ram_dout, ram_dout_oe, ram_oe_n, ram_we_n
    );

    modport slave (
        input  pi_req, pi_rw, pi_addr, pi_wdata, ram_din,
        output pi_ack, pi_rdata, pi_err, ram_addr, ram_dout, ram_dout_oe, ram_oe_n, ram_we_n
    );
endinterface

// File: rtl/bus_arbiter.sv
// Shares the SRAM/IO bus between the Pi (one latched transaction per full Pi slot) and the 6502.
// Optional pending-request abort is enabled with `define BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
    parameter int ADDR_WIDTH     = 17,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk16,
    input  logic                  reset_n,
    input  logic                  pi_select,
    input  logic                  pi_strobe,
    input  logic                  cpu_select,
    input  logic                  cpu_strobe,
    input  logic [15:0]           cpu_addr,
    input  logic                  cpu_rw,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  bus_conflict,
    bus_arbiter_if.slave          bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PENDING = 2'd1;
    localparam logic [1:0] ACTIVE  = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]            state;
    logic                  pi_sel_q;
    logic                  rise;
    logic                  fall;
    logic                  rw_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [ADDR_WIDTH-1:0] hold_addr;

    assign rise = pi_select & ~pi_sel_q;
    assign fall = ~pi_select & pi_sel_q;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 expired;
    logic                 err_q;

    assign expired = (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk16 or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= (state == PENDING && !rise) ? wait_cnt + 1'b1 : '0;
            if (state == PENDING && !rise && expired)
                err_q <= 1'b1;
            else if (state == IDLE)
                err_q <= 1'b0;
        end
    end

    assign bus.pi_err = (state == DONE) & err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign bus.pi_err     = 1'b0;
`endif

    // NOTE: all state here is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk16 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            pi_sel_q     <= 1'b0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            hold_addr    <= '0;
            bus.pi_rdata <= '0;
            bus_conflict <= 1'b0;
        end else begin
            pi_sel_q  <= pi_select;
            hold_addr <= bus.ram_addr;
            if (pi_select && cpu_select)
                bus_conflict <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.pi_req) begin
                        rw_q    <= bus.pi_rw;
                        addr_q  <= bus.pi_addr;
                        wdata_q <= bus.pi_wdata;
                        state   <= PENDING;
                    end
                end
                PENDING: begin
                    // Only a fresh rise starts the access, so a partial slot is never used.
                    if (rise)
                        state <= ACTIVE;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    else if (expired)
                        state <= DONE;
`endif
                end
                ACTIVE: begin
                    if (rw_q && pi_strobe)
                        bus.pi_rdata <= bus.ram_din;
                    if (fall)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pi_ack = (state == DONE);

    // NOTE: every output gets a default first, so no path through this block infers a latch.
    always_comb begin
        bus.ram_addr    = hold_addr;
        bus.ram_dout    = '0;
        bus.ram_dout_oe = 1'b0;
        bus.ram_oe_n    = 1'b1;
        bus.ram_we_n    = 1'b1;
        if (state == ACTIVE) begin
            bus.ram_addr = addr_q;
            if (rw_q) begin
                bus.ram_oe_n = 1'b0;
            end else begin
                bus.ram_dout    = wdata_q;
                bus.ram_dout_oe = 1'b1;
                bus.ram_we_n    = ~pi_strobe;
            end
        end else if (cpu_select) begin
            bus.ram_addr = ADDR_WIDTH'(cpu_addr);
            bus.ram_oe_n = ~cpu_rw;
            if (!cpu_rw) begin
                bus.ram_dout    = cpu_wdata;
                bus.ram_dout_oe = 1'b1;
                bus.ram_we_n    = ~cpu_strobe;
            end
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: 16-cycle slot generator, SRAM model, ack scoreboard.
// Build with +define+BUS_ARBITER_TIMEOUT_EN to also exercise the pending-request abort.
module tb_bus_arbiter;
    localparam int AW = 17;
    localparam int DW = 8;

    logic          clk16 = 1'b0;
    logic          reset_n;
    logic          pi_select, pi_strobe, cpu_select, cpu_strobe;
    logic [15:0]   cpu_addr;
    logic          cpu_rw;
    logic [DW-1:0] cpu_wdata;
    logic          bus_conflict;

    always #5 clk16 = ~clk16;

    bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(64)) dut (
        .clk16        (clk16),
        .reset_n      (reset_n),
        .pi_select    (pi_select),
        .pi_strobe    (pi_strobe),
        .cpu_select   (cpu_select),
        .cpu_strobe   (cpu_strobe),
        .cpu_addr     (cpu_addr),
        .cpu_rw       (cpu_rw),
        .cpu_wdata    (cpu_wdata),
        .bus_conflict (bus_conflict),
        .bus          (bus)
    );

    logic [7:0] sram [0:(1<<AW)-1];
    assign bus.ram_din = sram[bus.ram_addr];

    typedef struct { logic rw; logic [AW-1:0] addr; logic [7:0] data; logic pre; logic [7:0] exp_rd; } pi_vec_t;
    typedef struct { logic [15:0] addr; logic [7:0] data; } cpu_vec_t;
    typedef struct { logic [7:0] rdata; logic err; } exp_t;

    exp_t    sb[$];
    int      n_cmp = 0, n_fail = 0;
    int      phase = 0, cycle = 0;
    logic    slots_en = 1'b1, overlap = 1'b0;
    int      viol = 0, bad_we = 0, any_bus = 0, pi_bus = 0, ack_cnt = 0, ack_tick = 0;
    logic [AW-1:0] pi_we_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clk16 cycle: SRAM commit at the edge, drive next slot phase at +1, monitor at +3.
    task automatic tick();
        logic          wr;
        logic [AW-1:0] wa;
        logic [7:0]    wd;
        exp_t          e;
        wr = !bus.ram_we_n && bus.ram_dout_oe;
        wa = bus.ram_addr;
        wd = bus.ram_dout;
        @(posedge clk16);
        if (wr) sram[wa] = wd;
        #1;
        phase      = (phase + 1) % 16;
        pi_select  = slots_en && (phase == 2 || phase == 3);
        pi_strobe  = slots_en && (phase == 3);
        cpu_select = slots_en && (phase >= 10 || (overlap && (phase == 2 || phase == 3)));
        cpu_strobe = slots_en && (phase == 13);
        #2;
        cycle++;
        if (!bus.ram_oe_n && !bus.ram_we_n) viol++;
        if (bus.ram_dout_oe && !bus.ram_oe_n) viol++;
        if (!bus.ram_we_n && !pi_strobe && !cpu_strobe) bad_we++;
        if (!bus.ram_oe_n || !bus.ram_we_n || bus.ram_dout_oe) begin
            any_bus++;
            if (phase == 3 || phase == 4) pi_bus++;
        end
        if (!bus.ram_we_n && pi_strobe) pi_we_addr = bus.ram_addr;
        if (bus.pi_ack === 1'b1) begin
            ack_cnt++;
            ack_tick = cycle;
            check("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("ack_rdata", bus.pi_rdata, e.rdata);
                check("ack_err", bus.pi_err, e.err);
            end
        end
    endtask

    // Issue one Pi request, push its expected completion, wait (bounded) for the ack.
    task automatic pi_txn(input logic rw, input logic [AW-1:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp_rd, input logic exp_err, output int lat);
        int   t0, acks0;
        logic got;
        exp_t e;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb.push_back(e);
        bus.pi_rw    = rw;
        bus.pi_addr  = addr;
        bus.pi_wdata = wdata;
        bus.pi_req   = 1'b1;
        t0    = cycle;
        acks0 = ack_cnt;
        got   = 1'b0;
        lat   = -1;
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            if (ack_cnt != acks0) got = 1'b1;
        end
        bus.pi_req = 1'b0;
        check("ack_within_budget", got, 1);
        if (got) lat = ack_tick - t0 - 1;
        else sb.delete();
    endtask

    pi_vec_t  pvec[7];
    cpu_vec_t cvec[2];

    initial begin
        int lat, prev_ack, min_gap, snap, acks0;
        logic found;

        pvec[0] = '{1'b0, 17'h08000, 8'hA5, 1'b0, 8'h00};
        pvec[1] = '{1'b1, 17'h1FFFF, 8'h00, 1'b1, 8'h3C};
        pvec[2] = '{1'b0, 17'h1FFFF, 8'hC3, 1'b0, 8'h3C};
        pvec[3] = '{1'b1, 17'h1FFFF, 8'h00, 1'b0, 8'hC3};
        pvec[4] = '{1'b0, 17'h00000, 8'hFF, 1'b0, 8'hC3};
        pvec[5] = '{1'b1, 17'h08000, 8'h00, 1'b0, 8'hA5};
        pvec[6] = '{1'b1, 17'h00000, 8'h00, 1'b0, 8'hFF};
        cvec[0] = '{16'h8000, 8'h42};
        cvec[1] = '{16'h0123, 8'h99};

        reset_n    = 1'b0;
        pi_select  = 1'b0; pi_strobe  = 1'b0;
        cpu_select = 1'b0; cpu_strobe = 1'b0;
        cpu_addr   = '0;   cpu_rw     = 1'b1; cpu_wdata = '0;
        bus.pi_req = 1'b0; bus.pi_rw  = 1'b0; bus.pi_addr = '0; bus.pi_wdata = '0;
        #12;
        check("rst_pi_ack", bus.pi_ack, 0);
        check("rst_pi_err", bus.pi_err, 0);
        check("rst_pi_rdata", bus.pi_rdata, 0);
        check("rst_bus_conflict", bus_conflict, 0);
        check("rst_ram_oe_n", bus.ram_oe_n, 1);
        check("rst_ram_we_n", bus.ram_we_n, 1);
        check("rst_ram_dout_oe", bus.ram_dout_oe, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_dout", bus.ram_dout, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();

        // Table of Pi transactions issued back-to-back.
        min_gap  = 1000;
        prev_ack = 0;
        for (int i = 0; i < 7; i++) begin
            if (pvec[i].pre) sram[pvec[i].addr] = pvec[i].exp_rd;
            pi_txn(pvec[i].rw, pvec[i].addr, pvec[i].data, pvec[i].exp_rd, 1'b0, lat);
            if (!pvec[i].rw) check("pi_mem_write", sram[pvec[i].addr], pvec[i].data);
            if (i > 0 && ack_tick - prev_ack < min_gap) min_gap = ack_tick - prev_ack;
            prev_ack = ack_tick;
        end
        check("ack_spacing_ge_frame", 32'(min_gap >= 16), 1);

        // Table of CPU writes in the CPU slot with the Pi idle.
        for (int i = 0; i < 2; i++) begin
            cpu_addr  = cvec[i].addr;
            cpu_wdata = cvec[i].data;
            cpu_rw    = 1'b0;
            for (int k = 0; k < 32 && phase != 13; k++) tick();
            check("cpu_ram_addr", bus.ram_addr, {1'b0, cvec[i].addr});
            check("cpu_we_n_at_strobe", bus.ram_we_n, 0);
            check("cpu_ram_dout", bus.ram_dout, cvec[i].data);
            for (int k = 0; k < 32 && phase != 0; k++) tick();
            check("ram_addr_holds", bus.ram_addr, {1'b0, cvec[i].addr});
            cpu_rw = 1'b1;
            check("cpu_mem_write", sram[{1'b0, cvec[i].addr}], cvec[i].data);
        end

        // Late request: raised one cycle after the Pi slot rises, must wait a full frame.
        for (int k = 0; k < 32 && phase != 2; k++) tick();
        snap = pi_bus;
        tick();
        pi_txn(1'b1, 17'h08000, 8'h00, 8'h42, 1'b0, lat);
        check("late_latency_14_17", 32'(lat >= 14 && lat <= 17), 1);
        check("late_pi_bus_cycles", pi_bus - snap, 2);

        // Overlapping slots: Pi owns the bus, conflict flag is sticky.
        overlap = 1'b1;
        pi_txn(1'b0, 17'h00010, 8'h66, 8'h42, 1'b0, lat);
        check("conflict_pi_addr", pi_we_addr, 17'h00010);
        check("conflict_mem", sram[17'h00010], 8'h66);
        check("conflict_flag", bus_conflict, 1);
        overlap = 1'b0;
        repeat (16) tick();
        check("conflict_sticky", bus_conflict, 1);

        // Reset during an active Pi write.
        sram[17'h00300] = 8'hEE;
        bus.pi_rw = 1'b0; bus.pi_addr = 17'h00300; bus.pi_wdata = 8'h11; bus.pi_req = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (!bus.ram_we_n) found = 1'b1;
        end
        check("reached_active_write", found, 1);
        bus.pi_req = 1'b0;
        reset_n    = 1'b0;
        #1;
        check("midrst_we_n", bus.ram_we_n, 1);
        check("midrst_pi_ack", bus.pi_ack, 0);
        check("midrst_dout_oe", bus.ram_dout_oe, 0);
        check("midrst_ram_addr", bus.ram_addr, 0);
        check("midrst_pi_rdata", bus.pi_rdata, 0);
        check("midrst_conflict", bus_conflict, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        acks0 = ack_cnt;
        repeat (40) tick();
        check("no_ack_after_reset", ack_cnt - acks0, 0);
        check("aborted_write_no_commit", sram[17'h00300], 8'hEE);
        pi_txn(1'b1, 17'h00300, 8'h00, 8'hEE, 1'b0, lat);

`ifdef BUS_ARBITER_TIMEOUT_EN
        // Timeout: no slots at all, request must abort after 64 cycles with no bus access.
        slots_en = 1'b0;
        repeat (2) tick();
        snap = any_bus;
        pi_txn(1'b1, 17'h00300, 8'h00, 8'hEE, 1'b1, lat);
        check("timeout_latency", lat, 64);
        check("timeout_no_bus", any_bus - snap, 0);
        slots_en = 1'b1;
        repeat (4) tick();
`endif

        check("invariant_violations", viol, 0);
        check("we_n_outside_strobe", bad_we, 0);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single SRAM/IO bus between the Raspberry Pi (SPI bridge) and the 6502, using the slot strobes from the clk16 bus timing generator.
- Accepts one Pi transaction at a time via req/ack and holds it until the next full Pi slot, then executes it.
- Multiplexes CPU address, data and control onto the bus during the CPU slot.
- Sits between the timing generator, SPI bridge, CPU core and the SRAM pins.

Parameters:
- ADDR_WIDTH, 17, RAM address width (128 KiB).
- DATA_WIDTH, 8, data width.
- TIMEOUT_CYCLES, 64, clk16 cycles a Pi request may stay pending before abort. Used only with the optional feature.

Ports:
- clk16  in  1  16 MHz system clock
- reset_n  in  1  asynchronous active-low reset
- pi_select  in  1  Pi slot window from timing generator
- pi_strobe  in  1  Pi write strobe from timing generator
- cpu_select  in  1  CPU slot window
- cpu_strobe  in  1  CPU write strobe
- pi_req  in  1  Pi transaction request (level)
- pi_rw  in  1  1=read, 0=write
- pi_addr  in  ADDR_WIDTH  Pi address
- pi_wdata  in  DATA_WIDTH  Pi write data
- pi_ack  out  1  one-cycle completion pulse
- pi_rdata  out  DATA_WIDTH  captured read data
- pi_err  out  1  completion was an abort (optional feature only; else 0)
- cpu_addr  in  16  CPU address
- cpu_rw  in  1  CPU 1=read, 0=write
- cpu_wdata  in  DATA_WIDTH  CPU write data
- ram_addr  out  ADDR_WIDTH  bus address
- ram_din  in  DATA_WIDTH  bus read data
- ram_dout  out  DATA_WIDTH  bus write data
- ram_dout_oe  out  1  drive data bus
- ram_oe_n  out  1  SRAM output enable
- ram_we_n  out  1  SRAM write enable
- bus_conflict  out  1  sticky: pi_select and cpu_select were seen high together

Behaviour:
- Reset (async, reset_n=0):
  - State returns to IDLE and any pending transaction is dropped with no ack.
  - Outputs: pi_ack=0, pi_err=0, pi_rdata=0, bus_conflict=0, ram_oe_n=1, ram_we_n=1, ram_dout_oe=0, ram_addr=0, ram_dout=0.
- Edge detect: pi_select is registered to form pi_sel_q. Rise = pi_select & ~pi_sel_q. Fall = ~pi_select & pi_sel_q.
- FSM states: IDLE, PENDING, ACTIVE, DONE.
  - IDLE: if pi_req=1, latch pi_rw, pi_addr and pi_wdata, then go to PENDING. Requests are sampled only in IDLE.
  - PENDING: on rise, go to ACTIVE. A request latched while pi_select is already high waits for the next rise; partial slots are never used.
  - ACTIVE:
    - Read: on the clk16 edge where pi_strobe=1, capture ram_din into pi_rdata.
    - Write: commit happens while pi_strobe is high.
    - On fall, go to DONE.
  - DONE: pi_ack=1 for exactly one cycle, then go to IDLE. If pi_req is still high, the next transaction latches on the following cycle (back-to-back allowed). Minimum spacing between acks is one 16-cycle frame.
  - pi_rdata holds its value until the next Pi read capture.
- Bus mux (combinational from state and strobes):
  - ACTIVE:
    - ram_addr = latched pi_addr.
    - Read: ram_oe_n=0.
    - Write: ram_dout = latched wdata, ram_dout_oe=1 for the whole of ACTIVE, ram_we_n = ~pi_strobe.
  - cpu_select=1 and not ACTIVE:
    - ram_addr = {0, cpu_addr}.
    - ram_oe_n = ~cpu_rw.
    - Write: ram_dout = cpu_wdata, ram_dout_oe = ~cpu_rw, ram_we_n = ~(cpu_strobe & ~cpu_rw).
  - Otherwise: ram_oe_n=1, ram_we_n=1, ram_dout_oe=0, and ram_addr holds its last value.
- Priority:
  - If pi_select and cpu_select are both high, the Pi (ACTIVE) owns the bus and bus_conflict is set.
  - bus_conflict is cleared only by reset.
- ram_oe_n and ram_we_n are never both 0. ram_dout_oe=1 implies ram_oe_n=1.

Optional Feature:
- Macro BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter runs while the FSM is in PENDING.
  - When the count reaches TIMEOUT_CYCLES with no rise, the FSM goes to DONE with pi_err=1 for the ack cycle, and no bus access occurs.
  - The counter clears on leaving PENDING.
- Undefined: PENDING waits indefinitely, and pi_err is tied to 0.

Test Plan:
- Pi write: pi_req with rw=0, addr=0x08000, wdata=0xA5 → ram_we_n low exactly while pi_strobe is high in the next slot; SRAM[0x08000]=0xA5; one pi_ack pulse.
- Pi read: preload SRAM[0x1FFFF]=0x3C, pi_req with rw=1 → ram_oe_n low during the slot; pi_rdata=0x3C at pi_ack; pi_err=0.
- Late request: assert pi_req one cycle after pi_select rises → no bus activity in that slot; access and ack occur in the following frame (ack 14–17 cycles later).
- CPU slot: cpu_rw=0, cpu_addr=0x8000, wdata=0x42, Pi idle → ram_addr=0x08000, ram_we_n low only with cpu_strobe; SRAM[0x08000]=0x42.
- Reset mid-op: drop reset_n during ACTIVE write → ram_we_n=1 and pi_ack=0 immediately; FSM is in IDLE after release.
- Timeout (BUS_ARBITER_TIMEOUT_EN, pi_select held 0): pi_req → pi_ack with pi_err=1 after 64 cycles; no ram_we_n/ram_oe_n activity.
